// File: rtl/rx_frame_decoder.sv
// rx_frame_decoder: receive-side MII-style byte stream decoder.
// Hunts for a 0x55 preamble followed by the 0xD5 SFD, then forwards
// the frame bytes with a one-cycle latency, runs the Ethernet FCS over
// them and reports length / CRC / framing status with a finish strobe.
// Optional build macro: RX_FCS_STRIP_EN. When defined, a 4-byte delay
// line holds back the trailing FCS so it is never forwarded. The FCS
// bytes are still checked and still counted in o_len.
module rx_frame_decoder #(
  parameter int pDATA_WIDTH = 8,
  parameter int pMAX_FRAME  = 1522,
  parameter int pMIN_FRAME  = 64,
  parameter int pMIN_PRE    = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_dv_RX,
  input  logic                   i_er_RX,
  input  logic [pDATA_WIDTH-1:0] i_data_RX,
  output logic [pDATA_WIDTH-1:0] o_data_RX,
  output logic                   o_RX_data_valid,
  output logic                   o_RX_finish,
  output logic [10:0]            o_len,
  output logic                   o_crc_ok,
  output logic                   o_frame_err
);

  localparam logic [10:0]            MAX_LEN     = 11'(pMAX_FRAME);
  localparam logic [10:0]            MIN_LEN     = 11'(pMIN_FRAME);
  localparam logic [2:0]             PRE_MIN     = 3'(pMIN_PRE);
  localparam logic [31:0]            CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0]            CRC_RESIDUE = 32'hC704_DD7B;
  localparam logic [pDATA_WIDTH-1:0] PRE_BYTE    = pDATA_WIDTH'(8'h55);
  localparam logic [pDATA_WIDTH-1:0] SFD_BYTE    = pDATA_WIDTH'(8'hD5);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  // Ethernet CRC-32, MSB-first register with each byte fed LSB first.
  // Running it across data plus FCS leaves the fixed residue C704DD7B.
  function automatic logic [31:0] eth_crc32_8d(input logic [31:0]            crc,
                                               input logic [pDATA_WIDTH-1:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < pDATA_WIDTH; i++) begin
      if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ 32'h04C1_1DB7;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  // Length counter saturates at the top of the 11-bit field.
  function automatic logic [10:0] len_inc(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  // Preamble counter saturates at 7.
  function automatic logic [2:0] pre_inc(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  state_t                   state_q, state_d;
  logic [2:0]               pre_cnt_q, pre_cnt_d;
  logic [10:0]              len_q, len_d;
  logic [31:0]              crc_q, crc_d;
  logic                     err_q, err_d;
  logic [pDATA_WIDTH-1:0]   data_q, data_d;
  logic                     dvld_q, dvld_d;
  logic                     fin_q, fin_d;
  logic [10:0]              olen_q, olen_d;
  logic                     crc_ok_q, crc_ok_d;
  logic                     ferr_q, ferr_d;
  logic                     eof;

`ifdef RX_FCS_STRIP_EN
  logic [3:0][pDATA_WIDTH-1:0] dl_q;
  logic [2:0]                  fill_q, fill_d;
  logic                        dl_shift;
`endif

  // Next-state and next-output logic for the decoder FSM.
  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    len_d     = len_q;
    crc_d     = crc_q;
    err_d     = err_q;
    data_d    = data_q;
    dvld_d    = 1'b0;
    fin_d     = 1'b0;
    olen_d    = olen_q;
    crc_ok_d  = crc_ok_q;
    ferr_d    = ferr_q;
    eof       = 1'b0;
`ifdef RX_FCS_STRIP_EN
    fill_d    = fill_q;
    dl_shift  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (i_dv_RX && (i_data_RX == PRE_BYTE)) begin
          state_d   = ST_PRE;
          pre_cnt_d = 3'd1;
        end
      end

      ST_PRE: begin
        if (i_dv_RX && (i_data_RX == PRE_BYTE)) begin
          pre_cnt_d = pre_inc(pre_cnt_q);
        end else if (i_dv_RX && (i_data_RX == SFD_BYTE) && (pre_cnt_q >= PRE_MIN)) begin
          state_d = ST_DATA;
          crc_d   = CRC_INIT;
          len_d   = 11'd0;
          err_d   = 1'b0;
`ifdef RX_FCS_STRIP_EN
          fill_d  = 3'd0;
`endif
        end else begin
          // Anything else aborts the preamble silently.
          state_d = ST_IDLE;
        end
      end

      ST_DATA: begin
        if (!i_dv_RX) begin
          state_d = ST_IDLE;
          eof     = 1'b1;
        end else if (len_q == MAX_LEN) begin
          // One byte past the maximum: stop forwarding, flag oversize.
          state_d = ST_DROP;
          err_d   = 1'b1;
          len_d   = len_inc(len_q);
        end else begin
          crc_d = eth_crc32_8d(crc_q, i_data_RX);
          len_d = len_inc(len_q);
          if (i_er_RX) err_d = 1'b1;
`ifdef RX_FCS_STRIP_EN
          // Forward the byte sampled four bytes ago once the line is full.
          dl_shift = 1'b1;
          if (fill_q == 3'd4) begin
            data_d = dl_q[3];
            dvld_d = 1'b1;
          end else begin
            fill_d = fill_q + 3'd1;
          end
`else
          data_d = i_data_RX;
          dvld_d = 1'b1;
`endif
        end
      end

      ST_DROP: begin
        if (!i_dv_RX) begin
          state_d = ST_IDLE;
          eof     = 1'b1;
        end else begin
          len_d = len_inc(len_q);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Frame status is captured on end-of-frame and held until the next one.
    if (eof) begin
      fin_d    = 1'b1;
      olen_d   = len_q;
      crc_ok_d = (crc_q == CRC_RESIDUE);
      ferr_d   = err_q | (len_q < MIN_LEN);
    end
  end

  // State, counters and registered outputs; reset discards any frame in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      pre_cnt_q <= 3'd0;
      len_q     <= 11'd0;
      crc_q     <= CRC_INIT;
      err_q     <= 1'b0;
      data_q    <= '0;
      dvld_q    <= 1'b0;
      fin_q     <= 1'b0;
      olen_q    <= 11'd0;
      crc_ok_q  <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef RX_FCS_STRIP_EN
      fill_q    <= 3'd0;
`endif
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      len_q     <= len_d;
      crc_q     <= crc_d;
      err_q     <= err_d;
      data_q    <= data_d;
      dvld_q    <= dvld_d;
      fin_q     <= fin_d;
      olen_q    <= olen_d;
      crc_ok_q  <= crc_ok_d;
      ferr_q    <= ferr_d;
`ifdef RX_FCS_STRIP_EN
      fill_q    <= fill_d;
`endif
    end
  end

`ifdef RX_FCS_STRIP_EN
  // FCS hold-back delay line; contents are only used once fill reaches 4.
  always_ff @(posedge i_clk) begin
    if (dl_shift) dl_q <= {dl_q[2:0], i_data_RX};
  end
`endif

  assign o_data_RX       = data_q;
  assign o_RX_data_valid = dvld_q;
  assign o_RX_finish     = fin_q;
  assign o_len           = olen_q;
  assign o_crc_ok        = crc_ok_q;
  assign o_frame_err     = ferr_q;

endmodule

// File: tb/tb_rx_frame_decoder.sv
// tb_rx_frame_decoder: directed plus randomized frames checked against a
// frame-level reference model (reflected CRC-32, byte/finish scoreboard).
module tb_rx_frame_decoder;

  typedef logic [7:0] bq_t[$];

`ifdef RX_FCS_STRIP_EN
  localparam int DLY = 4;
`else
  localparam int DLY = 0;
`endif
  localparam int MAXF = 1522;
  localparam int MINF = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_dv = 1'b0;
  logic       i_er = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic [7:0] o_data;
  logic       o_vld;
  logic       o_fin;
  logic [10:0] o_len;
  logic       o_crc_ok;
  logic       o_ferr;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int clash = 0;

  // Scoreboard queues: expected from the model, actual from the monitor.
  logic [7:0] exp_b[$];
  int         exp_bc[$];
  int         exp_fc[$];
  int         exp_fl[$];
  logic       exp_fe[$];
  logic       exp_fok[$];
  logic       exp_fchk[$];
  logic [7:0] act_b[$];
  int         act_bc[$];
  int         act_fc[$];
  int         act_fl[$];
  logic       act_fe[$];
  logic       act_fok[$];

  rx_frame_decoder dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_dv_RX        (i_dv),
    .i_er_RX        (i_er),
    .i_data_RX      (i_data),
    .o_data_RX      (o_data),
    .o_RX_data_valid(o_vld),
    .o_RX_finish    (o_fin),
    .o_len          (o_len),
    .o_crc_ok       (o_crc_ok),
    .o_frame_err    (o_ferr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_vld) begin
      act_b.push_back(o_data);
      act_bc.push_back(cyc);
    end
    if (o_fin) begin
      act_fc.push_back(cyc);
      act_fl.push_back(int'(o_len));
      act_fe.push_back(o_ferr);
      act_fok.push_back(o_crc_ok);
      if (o_vld) clash++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Standard reflected CRC-32 with final inversion (the value sent as FCS).
  function automatic logic [31:0] crc32(input bq_t b, input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t make_frame(input int np, input bit inj);
    bq_t f;
    logic [31:0] fcs;
    for (int i = 0; i < np; i++) f.push_back(8'($urandom));
    if (inj && np >= 2) begin
      f[0] = 8'h55;
      f[1] = 8'hD5;
    end
    fcs = crc32(f, np);
    for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
    return f;
  endfunction

  task automatic drv(input logic dv, input logic [7:0] d, input logic er);
    @(posedge clk);
    #1;
    i_dv = dv;
    i_data = d;
    i_er = er;
  endtask

  // Send one frame and record what the model says must come out.
  task automatic send(input bq_t fr, input int npre, input int er_idx, input int rst_at);
    int n;
    int e;
    bit pend;
    logic [7:0] pb;
    int pc;
    logic [31:0] fcs_rx;
    n = fr.size();
    pend = 0;
    pb = 8'h00;
    pc = 0;
    for (int p = 0; p < npre; p++) drv(1'b1, 8'h55, 1'b0);
    drv(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        @(posedge clk);
        #1;
        rst = 1'b1;
        i_dv = 1'b0;
        #1;
        chk("rst_mid_valid", o_vld, 0);
        chk("rst_mid_finish", o_fin, 0);
        chk("rst_mid_len", o_len, 0);
        chk("rst_mid_data", o_data, 0);
        chk("rst_mid_crc_ok", o_crc_ok, 0);
        chk("rst_mid_err", o_ferr, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
      if (pend) begin
        exp_b.push_back(pb);
        exp_bc.push_back(pc);
        pend = 0;
      end
      drv(1'b1, fr[i], (i == er_idx));
      e = i - DLY;
      if (i < MAXF && e >= 0) begin
        pend = 1;
        pb = fr[e];
        pc = cyc + 1;
      end
    end
    if (pend) begin
      exp_b.push_back(pb);
      exp_bc.push_back(pc);
    end
    drv(1'b0, 8'($urandom), 1'b0);
    exp_fc.push_back(cyc + 1);
    exp_fl.push_back((n > 2047) ? 2047 : n);
    exp_fe.push_back((er_idx >= 0 && er_idx < n) || n < MINF || n > MAXF);
    fcs_rx = {fr[n-1], fr[n-2], fr[n-3], fr[n-4]};
    exp_fok.push_back(crc32(fr, n - 4) == fcs_rx);
    exp_fchk.push_back(n <= MAXF);
  endtask

  task automatic drain(input string tag);
    int m;
    int nbad;
    for (int i = 0; i < 3; i++) drv(1'b0, 8'($urandom), 1'b0);
    chk({tag, "_fin_count"}, act_fc.size(), exp_fc.size());
    m = (act_fc.size() < exp_fc.size()) ? act_fc.size() : exp_fc.size();
    for (int i = 0; i < m; i++) begin
      chk({tag, "_fin_cycle"}, act_fc[i], exp_fc[i]);
      chk({tag, "_len"}, act_fl[i], exp_fl[i]);
      chk({tag, "_frame_err"}, act_fe[i], exp_fe[i]);
      if (exp_fchk[i]) chk({tag, "_crc_ok"}, act_fok[i], exp_fok[i]);
    end
    if (exp_fl.size() > 0) chk({tag, "_len_hold"}, o_len, exp_fl[exp_fl.size()-1]);
    chk({tag, "_byte_count"}, act_b.size(), exp_b.size());
    m = (act_b.size() < exp_b.size()) ? act_b.size() : exp_b.size();
    nbad = 0;
    for (int i = 0; i < m; i++)
      if (act_b[i] !== exp_b[i] || act_bc[i] !== exp_bc[i]) nbad++;
    chk({tag, "_byte_errors"}, nbad, 0);
    chk({tag, "_valid_at_finish"}, clash, 0);
    exp_b.delete(); exp_bc.delete(); exp_fc.delete(); exp_fl.delete();
    exp_fe.delete(); exp_fok.delete(); exp_fchk.delete();
    act_b.delete(); act_bc.delete(); act_fc.delete(); act_fl.delete();
    act_fe.delete(); act_fok.delete();
    clash = 0;
  endtask

  initial begin
    bq_t f1;
    bq_t f2;
    bq_t fr;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", o_vld, 0);
    chk("reset_finish", o_fin, 0);
    chk("reset_len", o_len, 0);
    chk("reset_data", o_data, 0);
    chk("reset_crc_ok", o_crc_ok, 0);
    chk("reset_err", o_ferr, 0);
    rst = 1'b0;
    drv(1'b0, 8'h00, 1'b0);

    // Good minimum-size frame.
    f1 = make_frame(60, 0);
    send(f1, 7, -1, -1);
    drain("good64");

    // Same frame with one payload bit flipped.
    f2 = f1;
    f2[10] = f2[10] ^ 8'h01;
    send(f2, 7, -1, -1);
    drain("badcrc");

    // Aborted preamble, then a good frame.
    for (int i = 0; i < 3; i++) drv(1'b1, 8'h55, 1'b0);
    drv(1'b1, 8'h12, 1'b0);
    drv(1'b0, 8'h00, 1'b0);
    drain("abort");
    send(make_frame(60, 0), 7, -1, -1);
    drain("after_abort");

    // Receive error mid-frame.
    send(make_frame(60, 0), 7, 20, -1);
    drain("rx_er");

    // Oversize, exact maximum, length saturation, runt.
    send(make_frame(1596, 0), 7, -1, -1);
    drain("oversize");
    send(make_frame(1518, 0), 7, -1, -1);
    drain("maxsize");
    send(make_frame(2096, 0), 7, -1, -1);
    drain("len_sat");
    send(make_frame(36, 0), 7, -1, -1);
    drain("runt");

    // Reset mid-frame, then a good frame.
    send(make_frame(60, 0), 7, -1, 30);
    drain("rst_mid");
    send(make_frame(60, 0), 7, -1, -1);
    drain("after_rst");

    // Back-to-back random frames with one idle cycle between them.
    for (int k = 0; k < 8; k++) begin
      fr = make_frame($urandom_range(300, 46), (k == 2));
      if ($urandom_range(3, 0) == 0) fr[$urandom_range(20, 0)] ^= 8'h80;
      send(fr, (k == 0) ? 1 : $urandom_range(7, 1),
           ($urandom_range(3, 0) == 0) ? $urandom_range(40, 0) : -1, -1);
    end
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
